udma_hyper_trans_queue: RTL

- Consumer side of the hyperbus register interface's transaction handshake.
- Snapshots one transaction descriptor from the register file on each accepted push, buffers descriptors in a FIFO, and issues them one at a time to the hyperbus transaction engine.
- Waits for the engine to report completion before issuing the next descriptor.
- Returns queue occupancy (nb_trans_waiting_o) and busy_o to the register interface for its STATUS read.

---
 rtl/udma_hyper_trans_queue.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/udma_hyper_trans_queue.sv
// Hyperbus transaction queue: buffers register-file descriptors and issues them one at a time.
// Optional sticky overflow detection is enabled by defining UDMA_HYPER_QUEUE_OVF_EN.
module udma_hyper_trans_queue #(
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned TRANS_SIZE     = 16,
  parameter int unsigned MAX_NB_TRAN    = 8,
  parameter int unsigned QUEUE_DEPTH    = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [31:0]                 in_hyper_addr_i,
  input  logic [2:0]                  in_ctrl_i,
  input  logic [L2_AWIDTH_NOAL-1:0]   in_l2_addr_i,
  input  logic [TRANS_SIZE-1:0]       in_size_i,
  input  logic [2+4*TRANS_SIZE-1:0]   in_twd_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [31:0]                 out_hyper_addr_o,
  output logic [2:0]                  out_ctrl_o,
  output logic [L2_AWIDTH_NOAL-1:0]   out_l2_addr_o,
  output logic [TRANS_SIZE-1:0]       out_size_o,
  output logic [2+4*TRANS_SIZE-1:0]   out_twd_o,
  input  logic                        trans_done_i,
  output logic [MAX_NB_TRAN:0]        nb_trans_waiting_o,
  output logic                        busy_o,
  output logic                        err_overflow_o
);

  localparam int unsigned TwdW = 2 + 4 * TRANS_SIZE;
  localparam int unsigned EntW = 32 + 3 + L2_AWIDTH_NOAL + TRANS_SIZE + TwdW;
  localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CntW = MAX_NB_TRAN + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StBusy} state_e;

  state_e            r_state, w_state_nxt;
  logic [EntW-1:0]   r_mem [QUEUE_DEPTH];
  logic [EntW-1:0]   r_out_entry;
  logic [EntW-1:0]   w_in_entry;
  logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr, w_wr_ptr_inc, w_rd_ptr_inc;
  logic [CntW-1:0]   r_count;
  logic              w_push, w_pop, w_load_out;

  assign w_in_entry = {in_hyper_addr_i, in_ctrl_i, in_l2_addr_i, in_size_i, in_twd_i};
  assign {out_hyper_addr_o, out_ctrl_o, out_l2_addr_o, out_size_o, out_twd_o} = r_out_entry;

  assign in_ready_o         = (r_count != CntW'(QUEUE_DEPTH));
  assign out_valid_o        = (r_state == StIssue);
  assign busy_o             = (r_state != StIdle);
  assign nb_trans_waiting_o = r_count;

  // A push coinciding with a flush is discarded.
  assign w_push = in_valid_i & in_ready_o & ~clr_i;
  assign w_pop  = (r_state == StIssue) & out_ready_i;

  // Explicit wrap keeps non-power-of-2 depths correct.
  assign w_wr_ptr_inc = (r_wr_ptr == PtrW'(QUEUE_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_inc = (r_rd_ptr == PtrW'(QUEUE_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_ptr_inc;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        // Entries being flushed this cycle must not be issued.
        if ((r_count != '0) && !clr_i) w_state_nxt = StIssue;
      end
      StIssue: begin
        if (out_ready_i) begin
          w_state_nxt = StBusy;
        end else if (clr_i) begin
          w_state_nxt = StIdle;
        end
      end
      StBusy: begin
        if (trans_done_i) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_load_out = (r_state == StIdle) && (w_state_nxt == StIssue);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_out_entry <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_out) r_out_entry <= r_mem[r_rd_ptr];
    end
  end

`ifdef UDMA_HYPER_QUEUE_OVF_EN
  logic [4:0] r_stall_cnt;
  logic       r_err_ovf;
  logic       w_stall;

  assign w_stall        = in_valid_i & ~in_ready_o;
  assign err_overflow_o = r_err_ovf;

  // Counter saturates at 16; the 17th consecutive stalled cycle raises the flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
      r_err_ovf   <= 1'b0;
    end else if (clr_i) begin
      r_stall_cnt <= '0;
      r_err_ovf   <= 1'b0;
    end else if (w_stall) begin
      if (r_stall_cnt == 5'd16) begin
        r_err_ovf <= 1'b1;
      end else begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end else begin
      r_stall_cnt <= '0;
    end
  end
`else
  assign err_overflow_o = 1'b0;
`endif

endmodule
